// File: rtl/aes_enc_iter_core_pkg.sv
// Shared types, constants and round-function helpers for the iterative AES
// encryption core. Byte i of a 128-bit block sits at bits [127-8*i -: 8];
// bytes are column-major, so byte 4*c+r is row r of column c.
package aes_pkg;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_fsm_e;

  // Number of rounds for a key size; 0 flags an unsupported size.
  function automatic int nr_from_key_bits(input int key_bits);
    int nr;
    case (key_bits)
      128:     nr = 10;
      192:     nr = 12;
      256:     nr = 14;
      default: nr = 0;
    endcase
    return nr;
  endfunction

  // Forward S-box, entry 0 first.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r rotates left by r columns.
  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  // Each column multiplied by the circulant {02,03,01,01}.
  function automatic aes_state_t mix_columns(input aes_state_t s);
    aes_state_t o;
    logic [7:0] a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_enc_iter_core_if.sv
// Plaintext, round-key and ciphertext handshakes of the iterative AES core.
// The master side is the surrounding system, the slave side is the core.
interface aes_enc_iter_core_if #(
  parameter int KIDX_W = 4
) ();

  logic              aes_core_en;
  logic              pt_vld_i;
  logic              pt_rdy_o;
  logic [127:0]      pt_i;
  logic              key_req_o;
  logic [KIDX_W-1:0] key_idx_o;
  logic              key_vld_i;
  logic [127:0]      rkey_i;
  logic              ct_vld_o;
  logic              ct_rdy_i;
  logic [127:0]      ct_o;
  logic              busy_o;

  modport master (
    output aes_core_en, pt_vld_i, pt_i, key_vld_i, rkey_i, ct_rdy_i,
    input  pt_rdy_o, key_req_o, key_idx_o, ct_vld_o, ct_o, busy_o
  );

  modport slave (
    input  aes_core_en, pt_vld_i, pt_i, key_vld_i, rkey_i, ct_rdy_i,
    output pt_rdy_o, key_req_o, key_idx_o, ct_vld_o, ct_o, busy_o
  );

endinterface

// File: rtl/aes_enc_iter_core_sub_bytes.sv
// 128-bit SubBytes: sixteen parallel S-box lookups, purely combinational.
module aes_sub_bytes
  import aes_pkg::*;
(
  input  aes_state_t din,
  output aes_state_t dout
);

  // One table lookup per byte lane.
  always_comb begin
    dout = 128'h0;
    for (int i = 0; i < 16; i++) begin
      dout[8*i +: 8] = SBOX[din[8*i +: 8]];
    end
  end

endmodule

// File: rtl/aes_enc_iter_core.sv
// Iterative AES-128/192/256 encryption core. One round is computed per
// accepted round key; the key schedule lives outside and is fetched by index.
// Optional build macro AES_ENC_ROUND_TRACE_EN exposes the post-round state
// with a one-cycle valid pulse after every accepted key beat.
module aes_enc_iter_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128,
  parameter int KIDX_W   = 4
) (
  input logic aes_clk,
  input logic resetn,
  aes_enc_iter_core_if.slave bus
`ifdef AES_ENC_ROUND_TRACE_EN
  ,
  output logic [127:0] round_state_o,
  output logic         round_state_vld_o
`endif
);

  localparam int NR = nr_from_key_bits(KEY_BITS);
  localparam logic [KIDX_W-1:0] LAST_IDX = KIDX_W'(NR);
  localparam logic [KIDX_W-1:0] IDX_ZERO = {KIDX_W{1'b0}};
  localparam logic [KIDX_W-1:0] IDX_ONE  = {{(KIDX_W-1){1'b0}}, 1'b1};

  if (NR == 0) begin : g_bad_key_bits
    $error("aes_enc_iter_core: KEY_BITS must be 128, 192 or 256");
  end
  if ((2 ** KIDX_W) <= NR) begin : g_bad_kidx_w
    $error("aes_enc_iter_core: KIDX_W too narrow for the round count");
  end

  aes_fsm_e          fsm_r, fsm_nxt_s;
  aes_state_t        state_r, state_nxt_s;
  logic [KIDX_W-1:0] round_r, round_nxt_s;
  aes_state_t        ct_r, ct_nxt_s;
  logic              ct_vld_r, ct_vld_nxt_s;
  logic              run_r;
  logic              pt_rdy_s;
  aes_state_t        sb_s, sr_s, mc_s, round_out_s;

  aes_sub_bytes u_sub_bytes (
    .din  (state_r),
    .dout (sb_s)
  );

  // Round function: whitening on index 0, no MixColumns on the final round.
  always_comb begin
    sr_s = shift_rows(sb_s);
    mc_s = mix_columns(sr_s);
    if (round_r == IDX_ZERO) begin
      round_out_s = state_r ^ bus.rkey_i;
    end else if (round_r == LAST_IDX) begin
      round_out_s = sr_s ^ bus.rkey_i;
    end else begin
      round_out_s = mc_s ^ bus.rkey_i;
    end
  end

  // run_r keeps pt_rdy_o low while reset is applied and until the first edge after release.
  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

  assign pt_rdy_s = (fsm_r == IDLE) & bus.aes_core_en & run_r;

  // Next-state logic: enable low overrides everything and returns to IDLE.
  always_comb begin
    fsm_nxt_s    = fsm_r;
    state_nxt_s  = state_r;
    round_nxt_s  = round_r;
    ct_nxt_s     = ct_r;
    ct_vld_nxt_s = ct_vld_r;
    if (!bus.aes_core_en) begin
      fsm_nxt_s    = IDLE;
      round_nxt_s  = IDX_ZERO;
      ct_vld_nxt_s = 1'b0;
    end else begin
      case (fsm_r)
        IDLE: begin
          if (bus.pt_vld_i && pt_rdy_s) begin
            state_nxt_s = bus.pt_i;
            round_nxt_s = IDX_ZERO;
            fsm_nxt_s   = ROUND;
          end else begin
            fsm_nxt_s = IDLE;
          end
        end
        ROUND: begin
          if (bus.key_vld_i) begin
            state_nxt_s = round_out_s;
            if (round_r == LAST_IDX) begin
              ct_nxt_s     = round_out_s;
              ct_vld_nxt_s = 1'b1;
              round_nxt_s  = IDX_ZERO;
              fsm_nxt_s    = DONE;
            end else begin
              round_nxt_s = round_r + IDX_ONE;
            end
          end else begin
            fsm_nxt_s = ROUND;
          end
        end
        DONE: begin
          if (bus.ct_rdy_i) begin
            ct_vld_nxt_s = 1'b0;
            fsm_nxt_s    = IDLE;
          end else begin
            fsm_nxt_s = DONE;
          end
        end
        default: begin
          fsm_nxt_s    = IDLE;
          round_nxt_s  = IDX_ZERO;
          ct_vld_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // State, round index and ciphertext registers.
  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      fsm_r    <= IDLE;
      state_r  <= 128'h0;
      round_r  <= IDX_ZERO;
      ct_r     <= 128'h0;
      ct_vld_r <= 1'b0;
    end else begin
      fsm_r    <= fsm_nxt_s;
      state_r  <= state_nxt_s;
      round_r  <= round_nxt_s;
      ct_r     <= ct_nxt_s;
      ct_vld_r <= ct_vld_nxt_s;
    end
  end

  assign bus.pt_rdy_o  = pt_rdy_s;
  assign bus.key_req_o = (fsm_r == ROUND);
  assign bus.key_idx_o = round_r;
  assign bus.ct_vld_o  = ct_vld_r;
  assign bus.ct_o      = ct_r;
  assign bus.busy_o    = (fsm_r != IDLE);

`ifdef AES_ENC_ROUND_TRACE_EN
  logic beat_s;
  logic trace_vld_r;

  assign beat_s = (fsm_r == ROUND) & bus.aes_core_en & bus.key_vld_i;

  // Trace valid pulses the cycle after each accepted key beat.
  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      trace_vld_r <= 1'b0;
    end else begin
      trace_vld_r <= beat_s;
    end
  end

  assign round_state_o     = state_r;
  assign round_state_vld_o = trace_vld_r;
`endif

endmodule

// File: tb/tb_aes_enc_iter_core.sv
// Self-checking bench for aes_enc_iter_core (AES-128 and AES-256 instances).
// Reference: S-box derived from GF(2^8) inversion plus affine map, byte-array
// AES rounds and a standard key expansion, all computed in the bench.
module tb_aes_enc_iter_core;

  logic aes_clk;
  logic resetn;
  int checks;
  int errors;

  logic         sel256;
  logic         en;
  logic         pt_vld;
  logic [127:0] pt;
  logic         key_vld;
  logic [127:0] rkey;
  logic         ct_rdy;

  logic [7:0]   sb [0:255];
  logic [127:0] rk [0:14];

  aes_enc_iter_core_if #(.KIDX_W(4)) if128 ();
  aes_enc_iter_core_if #(.KIDX_W(4)) if256 ();

`ifdef AES_ENC_ROUND_TRACE_EN
  logic [127:0] tr128, tr256;
  logic         trv128, trv256;
`endif

  aes_enc_iter_core #(.KEY_BITS(128), .KIDX_W(4)) dut128 (
    .aes_clk (aes_clk),
    .resetn  (resetn),
    .bus     (if128)
`ifdef AES_ENC_ROUND_TRACE_EN
    , .round_state_o (tr128), .round_state_vld_o (trv128)
`endif
  );

  aes_enc_iter_core #(.KEY_BITS(256), .KIDX_W(4)) dut256 (
    .aes_clk (aes_clk),
    .resetn  (resetn),
    .bus     (if256)
`ifdef AES_ENC_ROUND_TRACE_EN
    , .round_state_o (tr256), .round_state_vld_o (trv256)
`endif
  );

  assign if128.aes_core_en = en;
  assign if128.pt_vld_i    = pt_vld & ~sel256;
  assign if128.pt_i        = pt;
  assign if128.key_vld_i   = key_vld & ~sel256;
  assign if128.rkey_i      = rkey;
  assign if128.ct_rdy_i    = ct_rdy & ~sel256;
  assign if256.aes_core_en = en;
  assign if256.pt_vld_i    = pt_vld & sel256;
  assign if256.pt_i        = pt;
  assign if256.key_vld_i   = key_vld & sel256;
  assign if256.rkey_i      = rkey;
  assign if256.ct_rdy_i    = ct_rdy & sel256;

  wire         o_pt_rdy  = sel256 ? if256.pt_rdy_o  : if128.pt_rdy_o;
  wire         o_key_req = sel256 ? if256.key_req_o : if128.key_req_o;
  wire [3:0]   o_key_idx = sel256 ? if256.key_idx_o : if128.key_idx_o;
  wire         o_ct_vld  = sel256 ? if256.ct_vld_o  : if128.ct_vld_o;
  wire [127:0] o_ct      = sel256 ? if256.ct_o      : if128.ct_o;
  wire         o_busy    = sel256 ? if256.busy_o    : if128.busy_o;

  initial begin
    aes_clk = 1'b0;
    forever #5 aes_clk = ~aes_clk;
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, xv;
    for (int x = 0; x < 256; x++) begin
      xv = 8'(x);
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, xv);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int kbits);
    logic [31:0] w [0:59];
    logic [31:0] tmp;
    logic [7:0]  rc;
    int nk, nr;
    nk = kbits / 32;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] ptv, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = ptv[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
          s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127-8*i -: 8];
    end
    o = 128'h0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aes_clk);
    @(negedge aes_clk);
  endtask

  // Drive one block from IDLE through the ciphertext handshake; rk[] must hold its keys.
  task automatic run_block(input logic [127:0] ptv, input int nr, input int max_gap,
                           input int bp, input logic [127:0] exp_ct);
    int gaps;
    chk1("pt_rdy_idle", o_pt_rdy, 1'b1);
    pt_vld = 1'b1;
    pt     = ptv;
    tick();
    pt_vld = 1'b0;
    chk1("busy_round", o_busy, 1'b1);
    chk1("key_req_round", o_key_req, 1'b1);
    for (int r = 0; r <= nr; r++) begin
      gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gaps; g++) begin
        key_vld = 1'b0;
        pt_vld  = 1'($urandom_range(0, 1));
        pt      = {$urandom, $urandom, $urandom, $urandom};
        tick();
        chk("key_idx_stall", 128'(o_key_idx), 128'(r));
        chk1("pt_rdy_busy", o_pt_rdy, 1'b0);
      end
      pt_vld  = 1'b0;
      key_vld = 1'b1;
      rkey    = rk[r];
      chk("key_idx", 128'(o_key_idx), 128'(r));
      chk1("ct_vld_early", o_ct_vld, 1'b0);
      tick();
    end
    key_vld = 1'b0;
    chk1("ct_vld_rise", o_ct_vld, 1'b1);
    chk("ct", o_ct, exp_ct);
    chk1("key_req_done", o_key_req, 1'b0);
    chk1("pt_rdy_done", o_pt_rdy, 1'b0);
    for (int b = 0; b < bp; b++) begin
      ct_rdy  = 1'b0;
      pt_vld  = 1'b1;
      key_vld = 1'($urandom_range(0, 1));
      tick();
      chk("ct_hold", o_ct, exp_ct);
      chk1("ct_vld_hold", o_ct_vld, 1'b1);
      chk1("pt_rdy_bp", o_pt_rdy, 1'b0);
    end
    pt_vld  = 1'b0;
    key_vld = 1'b0;
    ct_rdy  = 1'b1;
    tick();
    ct_rdy = 1'b0;
    chk1("ct_vld_clear", o_ct_vld, 1'b0);
    chk1("busy_idle", o_busy, 1'b0);
  endtask

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] C1_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin
    logic [127:0] rpt;
    logic [255:0] rkey_full;
    checks  = 0;
    errors  = 0;
    sel256  = 1'b0;
    resetn  = 1'b0;
    en      = 1'b1;
    pt_vld  = 1'b0;
    pt      = 128'h0;
    key_vld = 1'b0;
    rkey    = 128'h0;
    ct_rdy  = 1'b0;

    build_sbox();
    expand(C1_KEY, 128);
    chk("model_c1", aes_ref(C1_PT, 10), C1_CT);

    // Reset state, with enable already high.
    @(negedge aes_clk);
    chk1("rst_pt_rdy", o_pt_rdy, 1'b0);
    chk1("rst_key_req", o_key_req, 1'b0);
    chk("rst_key_idx", 128'(o_key_idx), 128'h0);
    chk1("rst_ct_vld", o_ct_vld, 1'b0);
    chk("rst_ct", o_ct, 128'h0);
    chk1("rst_busy", o_busy, 1'b0);
    @(negedge aes_clk);
    resetn = 1'b1;
    tick();

    // key_vld_i ignored while no key is requested.
    key_vld = 1'b1;
    tick();
    key_vld = 1'b0;
    chk1("idle_key_ignored", o_busy, 1'b0);

    // FIPS-197 C.1, keys held valid: ct_vld exactly 11 cycles after accept.
    run_block(C1_PT, 10, 0, 0, C1_CT);
    // Same vector with key stalls and 5 cycles of backpressure, back to back.
    run_block(C1_PT, 10, 3, 5, C1_CT);

    // Random keys/plaintexts with stalls and backpressure.
    for (int n = 0; n < 6; n++) begin
      rkey_full = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      rpt = {$urandom, $urandom, $urandom, $urandom};
      expand(rkey_full, 128);
      run_block(rpt, 10, 3, int'($urandom_range(0, 5)), aes_ref(rpt, 10));
    end

    // Abort after four beats, then a clean C.1 run.
    expand(C1_KEY, 128);
    pt_vld = 1'b1;
    pt = {$urandom, $urandom, $urandom, $urandom};
    tick();
    pt_vld = 1'b0;
    for (int r = 0; r < 4; r++) begin
      key_vld = 1'b1;
      rkey = rk[r];
      tick();
    end
    chk("abort_idx4", 128'(o_key_idx), 128'h4);
    en = 1'b0;
    tick();
    chk1("abort_key_req", o_key_req, 1'b0);
    chk1("abort_busy", o_busy, 1'b0);
    chk("abort_key_idx", 128'(o_key_idx), 128'h0);
    chk1("abort_pt_rdy", o_pt_rdy, 1'b0);
    en = 1'b1;
    key_vld = 1'b0;
    tick();
    run_block(C1_PT, 10, 0, 0, C1_CT);

    // Asynchronous reset in the middle of ROUND.
    pt_vld = 1'b1;
    pt = C1_PT;
    tick();
    pt_vld = 1'b0;
    key_vld = 1'b1;
    rkey = rk[0];
    tick();
    rkey = rk[1];
    tick();
    key_vld = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk1("arst_pt_rdy", o_pt_rdy, 1'b0);
    chk1("arst_key_req", o_key_req, 1'b0);
    chk("arst_key_idx", 128'(o_key_idx), 128'h0);
    chk1("arst_ct_vld", o_ct_vld, 1'b0);
    chk("arst_ct", o_ct, 128'h0);
    chk1("arst_busy", o_busy, 1'b0);
    @(negedge aes_clk);
    resetn = 1'b1;
    tick();
    chk1("arst_pt_rdy_after", o_pt_rdy, 1'b1);
    run_block(C1_PT, 10, 0, 0, C1_CT);

    // AES-256: FIPS-197 C.3 (key_idx 0..14 checked per beat) then a random block.
    sel256 = 1'b1;
    expand(C3_KEY, 256);
    chk("model_c3", aes_ref(C1_PT, 14), C3_CT);
    tick();
    run_block(C1_PT, 14, 0, 0, C3_CT);
    rkey_full = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    rpt = {$urandom, $urandom, $urandom, $urandom};
    expand(rkey_full, 256);
    run_block(rpt, 14, 3, 2, aes_ref(rpt, 14));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_enc_iter_core.md
Name: aes_enc_iter_core

Overview:
- Parametrised iterative AES encryption core: successor to the fixed AES-128 encryption core; supports AES-128/192/256 via parameter.
- Executes one AES round per accepted round key; round keys come from an external key-schedule block over a request/valid handshake.
- Sits between the plaintext source (valid/ready) and the ciphertext sink (valid/ready with backpressure).

Parameters:
- KEY_BITS, 128, key size: 128, 192 or 256. Any other value is an elaboration error. Derived NR = 10/12/14.
- KIDX_W, 4, width of the round-key index.

Ports:
- aes_clk  input  1  clock
- resetn  input  1  reset, asynchronous, active-low
- aes_core_en  input  1  core enable; low forces IDLE synchronously
- pt_vld_i  input  1  plaintext valid
- pt_rdy_o  output  1  core can accept plaintext
- pt_i  input  128  plaintext; byte 0 = [127:120]; FIPS-197 column-major order
- key_req_o  output  1  requesting round key key_idx_o
- key_idx_o  output  KIDX_W  index of requested round key, 0..NR
- key_vld_i  input  1  round key valid
- rkey_i  input  128  round key, same byte order as pt_i
- ct_vld_o  output  1  ciphertext valid
- ct_rdy_i  input  1  sink ready
- ct_o  output  128  ciphertext
- busy_o  output  1  state != IDLE

Behaviour:
- Reset values: all outputs 0 (pt_rdy_o 0, key_req_o 0, key_idx_o 0, ct_vld_o 0, ct_o 0, busy_o 0); state IDLE; state register 0.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - pt_rdy_o = aes_core_en.
  - pt_vld_i & pt_rdy_o: latch pt_i into the state register, key_idx <= 0, go to ROUND.
- ROUND:
  - key_req_o = 1; key_idx_o = current round index r.
  - Each cycle with key_vld_i = 1 is one accepted beat and updates state:
    - r = 0: state ^= rkey.
    - 1 <= r <= NR-1: ShiftRows(SubBytes(state)), then MixColumns, then ^ rkey.
    - r = NR: ShiftRows(SubBytes(state)) ^ rkey (no MixColumns).
  - After each beat r increments. After the beat with r = NR: ct_o <= result, ct_vld_o <= 1, go to DONE.
  - key_vld_i low: hold, no update, key_idx_o stable.
  - key_vld_i is ignored when key_req_o = 0.
- DONE:
  - ct_vld_o and ct_o held stable until ct_rdy_i = 1. On that cycle: ct_vld_o <= 0, go to IDLE.
  - pt_rdy_o = 0 in DONE; no bypass.
- Latency: with key_vld_i held high, ct_vld_o rises NR+1 cycles after the plaintext-accept edge (11/13/15). Throughput is one block per NR+3 cycles minimum.
- aes_core_en = 0 in any state: next edge goes to IDLE; ct_vld_o, key_req_o and key_idx_o cleared; state register retained but don't-care. A partly delivered key sequence is discarded.
- Reset mid-operation: immediate return to reset values. Nothing is flushed externally.
- pt_vld_i while busy: ignored (pt_rdy_o = 0).
- SubBytes: 16 parallel combinational S-box lookups.
- MixColumns: GF(2^8) xtime with reduction polynomial 0x11B.
- All datapath logic is combinational between the state register and the next-state value; a single registered stage per round.

Optional Feature:
- Macro: AES_ENC_ROUND_TRACE_EN.
- Defined: adds output ports round_state_o (128) and round_state_vld_o (1), pulsing for 1 cycle after every accepted beat and carrying the post-round state. Used for round-by-round FIPS-197 comparison.
- Undefined: ports absent; no extra flops. Functional behaviour is otherwise identical.

Decomposition:
- Package aes_pkg:
  - typedef aes_state_t (logic [127:0]).
  - typedef aes_fsm_e {IDLE, ROUND, DONE}.
  - Function nr_from_key_bits(), S-box constant table (256 x 8).
  - Functions xtime(), shift_rows(), mix_columns().
- Sub-module aes_sub_bytes: 128-bit combinational SubBytes using the package S-box; instanced once in the core.

Test Plan:
- AES-128, FIPS-197 C.1: pt 00112233445566778899aabbccddeeff, key 000102..0f, bench supplies expanded keys with key_vld_i held high -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, ct_vld_o exactly 11 cycles after accept.
- AES-256, FIPS-197 C.3: same pt, key 000102..1f -> ct 8ea2b7ca516745bfeafc49904b496089 after 15 key beats; key_idx_o sequence 0..14.
- Key stalls: random 0-3 cycle gaps in key_vld_i on the C.1 vector -> same ct; key_idx_o never advances without a beat.
- Backpressure: ct_rdy_i low 5 cycles -> ct_o/ct_vld_o stable; pt_rdy_o = 0 until the handshake completes; next block is accepted the cycle after the return to IDLE.
- Abort: drop aes_core_en after beat 4 -> IDLE next edge, key_req_o = 0. Re-enable and run C.1 -> correct ct.
- Async reset asserted mid-ROUND -> all outputs 0 immediately; after release, pt_rdy_o = 1 when aes_core_en = 1.
